elastic_pipeline: RTL
=====================

// Module: elastic_pipeline
// PURPOSE
//  Parametrised successor to the single-cycle pipeline register: a DEPTH-stage
//  elastic pipeline of WIDTH-bit words with valid/ready handshaking on both ends.
//  Each stage collapses bubbles, and stalls propagate backpressure upstream.
//  Data registers load only on accepted valid words, so masked shares never
//  toggle on bubbles. Used between AES round stages that may stall.
// PARAMETERS
//  WIDTH       32  bits per word (>=1)
//  DEPTH       3   number of register stages (>=1); stage 0 is nearest the input
//  CLEAR_DATA  0   1: data regs reset and flush to 0; 0: only valid bits reset
//  CNT_W       $clog2(DEPTH+1)  occupancy counter width (derived; do not override)
// PORTS
//  in_clock      in   1      clock, rising edge
//  in_reset      in   1      asynchronous reset, active-low
//  in_flush      in   1      synchronous flush; drops all stored words
//  in_data       in   WIDTH  upstream data
//  in_valid      in   1      upstream word valid
//  out_ready     out  1      pipeline can accept a word this cycle
//  out_data      out  WIDTH  data of last stage (DEPTH-1)
//  out_valid     out  1      last stage holds a valid word
//  in_ready      in   1      downstream accepts out_data this cycle
//  out_occupancy out  CNT_W  number of valid stages
// BEHAVIOUR
//  - Reset (in_reset=0, async): all valid bits=0, out_valid=0, out_occupancy=0.
//    Data regs become 0 if CLEAR_DATA=1, otherwise they keep their value.
//  - Transfer in: in_valid&&out_ready at the edge. Transfer out: out_valid&&in_ready.
//  - Stage enable: en[DEPTH-1] = !v[DEPTH-1] || in_ready.
//    For i<DEPTH-1: en[i] = !v[i] || en[i+1].
//    out_ready = en[0] && !in_flush. This path is combinational; there is no
//    registered-ready skid.
//  - On edge with en[i]: v[i] <= src_valid. src is in_valid for i=0, else v[i-1].
//    d[i] <= src_data only if src_valid=1. Otherwise d[i] holds its value.
//  - Stages with en[i]=0 hold v and d unchanged.
//  - Bubble collapse: a valid word advances into any empty stage ahead of it,
//    even when the output is stalled.
//  - Latency: DEPTH cycles from transfer-in to out_valid on an empty, unstalled
//    pipe. Throughput: 1 word/cycle while in_ready=1.
//  - Order is strictly FIFO. No word is duplicated or dropped except by flush.
//  - Full (all v=1) with in_ready=0: out_ready=0. out_data and out_valid are
//    held stable until accepted.
//  - Full with in_ready=1: simultaneous in and out transfer. Occupancy unchanged.
//  - Flush: next state has all v=0 and occupancy=0. in_valid is ignored.
//    out_ready=0 during the flush cycle. An out transfer presented in the same
//    cycle still counts as consumed. Data is zeroed only if CLEAR_DATA=1.
//  - Flush has priority over all loads. Async reset has priority over flush.
//  - out_occupancy is registered: it equals popcount(v) after every edge.
//    Max value is DEPTH, with no wrap.
//  - Reset asserted mid-operation discards all words. The first transfer is
//    accepted on the first edge after deassertion.
// TESTING
//  1. WIDTH=8,DEPTH=3: push 0x11,0x22,0x33 on consecutive cycles, in_ready=1
//     -> out_valid in cycles 3,4,5 with 0x11,0x22,0x33.
//  2. in_ready=0, push 4 words -> out_ready drops after 3 accepts. Occupancy=3.
//     4th word is held upstream. Then in_ready=1 -> all 4 exit in order.
//  3. Bubble: push A, idle 2 cycles, hold in_ready=0, push B
//     -> B collapses to stage 1 behind A. Occupancy=2.
//  4. Full pipe, in_flush=1 with in_valid=1 -> next cycle out_valid=0,
//     occupancy=0, word not accepted. Data=0 only when CLEAR_DATA=1.
//  5. Assert in_reset=0 asynchronously mid-stream -> out_valid=0 immediately.
//     After release, push 0x5A -> exits after 3 cycles.
//  6. Random valid/ready over 10k cycles vs scoreboard queue
//     -> no loss/reorder. d regs never change on bubble loads.

Source files
------------

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready pipeline with bubble collapse and flush
module elastic_pipeline #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 3,
  parameter bit CLEAR_DATA = 0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [CNT_W-1:0] out_occupancy
);
  logic [DEPTH-1:0] v, en, sv, ld, v_nxt;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] sd [DEPTH];
  logic [CNT_W-1:0] occ, occ_nxt;
  logic             full_tail;
  // Stage i can move when every stage from i to the end is full only if the sink drains
  always_comb begin
    full_tail = 1'b1;
    en = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      en[i] = !full_tail || in_ready;
    end
  end
  // Source of each stage, next valid bits, data load strobes and next occupancy
  always_comb begin
    sv[0] = in_valid;
    sd[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      sv[i] = v[i-1];
      sd[i] = d[i-1];
    end
    ld = in_flush ? '0 : (en & sv);
    v_nxt = in_flush ? '0 : ((en & sv) | (~en & v));
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + CNT_W'(v_nxt[i]);
  end
  // Valid bits and registered occupancy
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      v   <= '0;
      occ <= '0;
    end else begin
      v   <= v_nxt;
      occ <= occ_nxt;
    end
  end
  generate
    if (CLEAR_DATA) begin : g_clr
      // Data cleared by reset and flush; otherwise loads only on a valid source word
      always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
          for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (in_flush) d[i] <= '0;
            else if (ld[i]) d[i] <= sd[i];
          end
        end
      end
    end else begin : g_hold
      // Data never reset so shares stay quiet; loads only on a valid source word
      always_ff @(posedge in_clock) begin
        for (int i = 0; i < DEPTH; i++) if (in_reset && ld[i]) d[i] <= sd[i];
      end
    end
  endgenerate
  assign out_ready     = en[0] && !in_flush;
  assign out_valid     = v[DEPTH-1];
  assign out_data      = d[DEPTH-1];
  assign out_occupancy = occ;
endmodule
